// File: rtl/order_timer.sv
// order_timer: spawns one timed customer order at a pseudo-random delay, counts it down, scores serves/misses.
// Latency: every output is registered; each effect appears one pixel_clk_in cycle after the input is sampled.
// Backpressure: none; serve_in is a fire-and-forget pulse and is ignored unless an order is pending.
//
// Ports:
//   pixel_clk_in    - clock (pixel domain)
//   rst_n_in        - asynchronous active-low reset
//   frame_tick_in   - one-cycle pulse per frame (vblank); paces all countdowns
//   game_active_in  - level; low returns the block to IDLE, holding score and misses
//   serve_in        - one-cycle pulse, a correct dish was delivered
//   order_out       - an order is pending
//   order_time_out  - remaining countdown steps of the pending order (bar width)
//   served_out      - one-cycle pulse on a successful serve
//   expired_out     - one-cycle pulse when the pending order times out
//   score_out       - saturating sum of remaining time at each serve
//   miss_count_out  - saturating count of expired orders
module order_timer #(
  parameter int         FRAMES_PER_STEP = 60,
  parameter int         MAX_TIME        = 31,
  parameter int         MIN_SPAWN_DELAY = 2,
  parameter int         SPAWN_MASK      = 7,
  parameter int         RESULT_HOLD     = 30,
  parameter logic [7:0] LFSR_SEED       = 8'hA5
) (
  input  logic       pixel_clk_in,
  input  logic       rst_n_in,
  input  logic       frame_tick_in,
  input  logic       game_active_in,
  input  logic       serve_in,
  output logic       order_out,
  output logic [4:0] order_time_out,
  output logic       served_out,
  output logic       expired_out,
  output logic [7:0] score_out,
  output logic [3:0] miss_count_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACTIVE = 2'd2,
    RESULT = 2'd3
  } state_t;

  // One frame-tick counter serves both as the step prescaler (WAIT/ACTIVE)
  // and as the hold counter (RESULT), so it is sized for the larger of the two.
  localparam int CNT_MAX = (FRAMES_PER_STEP > RESULT_HOLD) ? FRAMES_PER_STEP : RESULT_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int DLY_W   = $clog2(MIN_SPAWN_DELAY + 8 + 1);

  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(FRAMES_PER_STEP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESULT_HOLD - 1);
  localparam logic [2:0]       MASK3     = 3'(SPAWN_MASK);
  localparam logic [4:0]       TIME_INIT = 5'(MAX_TIME);
  localparam logic [DLY_W-1:0] DLY_ONE   = DLY_W'(1);

  state_t           state;
  logic [CNT_W-1:0] pre_cnt;
  logic [DLY_W-1:0] delay_cnt;
  logic [7:0]       lfsr_q;

  logic             step;
  logic [DLY_W-1:0] delay_load;
  logic [8:0]       score_sum;

  // Galois LFSR, x^8+x^6+x^5+x^4+1 in right-shift form (tap mask 0xB8).
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
    end
  end

  // A step only ever coincides with a frame tick, which keeps the bar
  // width stable within a frame.
  assign step       = frame_tick_in && (pre_cnt == STEP_LAST);
  assign delay_load = DLY_W'(MIN_SPAWN_DELAY) + DLY_W'(lfsr_q[2:0] & MASK3);
  assign score_sum  = {1'b0, score_out} + {4'd0, order_time_out};

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state          <= IDLE;
      pre_cnt        <= '0;
      delay_cnt      <= '0;
      order_out      <= 1'b0;
      order_time_out <= 5'd0;
      served_out     <= 1'b0;
      expired_out    <= 1'b0;
      score_out      <= 8'd0;
      miss_count_out <= 4'd0;
    end else begin
      served_out  <= 1'b0;
      expired_out <= 1'b0;

      // Dropping game_active overrides serve and step; totals are kept for display.
      if (state != IDLE && !game_active_in) begin
        state          <= IDLE;
        pre_cnt        <= '0;
        delay_cnt      <= '0;
        order_out      <= 1'b0;
        order_time_out <= 5'd0;
      end else begin
        case (state)
          IDLE: begin
            if (game_active_in) begin
              score_out      <= 8'd0;
              miss_count_out <= 4'd0;
              delay_cnt      <= delay_load;
              pre_cnt        <= '0;
              state          <= WAIT;
            end
          end

          WAIT: begin
            if (frame_tick_in) begin
              pre_cnt <= step ? '0 : pre_cnt + 1'b1;
              if (step) begin
                if (delay_cnt == DLY_ONE) begin
                  state          <= ACTIVE;
                  order_out      <= 1'b1;
                  order_time_out <= TIME_INIT;
                end else begin
                  delay_cnt <= delay_cnt - 1'b1;
                end
              end
            end
          end

          ACTIVE: begin
            if (serve_in) begin
              // Score the time shown this cycle, before any coincident step.
              served_out     <= 1'b1;
              score_out      <= score_sum[8] ? 8'hFF : score_sum[7:0];
              order_out      <= 1'b0;
              order_time_out <= 5'd0;
              pre_cnt        <= '0;
              state          <= RESULT;
            end else if (frame_tick_in) begin
              pre_cnt <= step ? '0 : pre_cnt + 1'b1;
              if (step) begin
                if (order_time_out == 5'd1) begin
                  expired_out    <= 1'b1;
                  miss_count_out <= (miss_count_out == 4'hF) ? 4'hF : miss_count_out + 1'b1;
                  order_out      <= 1'b0;
                  order_time_out <= 5'd0;
                  pre_cnt        <= '0;
                  state          <= RESULT;
                end else begin
                  order_time_out <= order_time_out - 1'b1;
                end
              end
            end
          end

          RESULT: begin
            if (frame_tick_in) begin
              if (pre_cnt == HOLD_LAST) begin
                delay_cnt <= delay_load;
                pre_cnt   <= '0;
                state     <= WAIT;
              end else begin
                pre_cnt <= pre_cnt + 1'b1;
              end
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
